case_mul_pipe_sat: RTL and testbench

//  Parametrised pipelined multiplier, successor to the single-cycle signed mul cores.

---
 rtl/case_mul_pipe_sat.sv | 134 +++++++++++++
 tb/tb_case_mul_pipe_sat.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/case_mul_pipe_sat.sv
// case_mul_pipe_sat: pipelined fixed-point multiplier with round/shift/saturate,
// valid/ready flow control, flush and a saturating overflow event counter.
module case_mul_pipe_sat #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 14,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 14,
  parameter int SIGNED0    = 1,
  parameter int SIGNED1    = 1,
  parameter int SHIFT      = 10,
  parameter int ROUND      = 1,
  parameter int SATURATE   = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf,
  output logic [CNT_WIDTH-1:0]  ovf_cnt
);

  localparam int P  = din0_WIDTH + din1_WIDTH;
  localparam int Q  = ((P > dout_WIDTH) ? P : dout_WIDTH) + 2;
  localparam int DW = dout_WIDTH;
  localparam int N  = NUM_STAGE;

  localparam bit S0 = (SIGNED0 != 0);
  localparam bit S1 = (SIGNED1 != 0);
  localparam bit OS = S0 | S1;

  localparam logic signed [Q-1:0] ONE = Q'(1);
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [Q-1:0] RND =
    (ROUND != 0 && SHIFT > 0) ? (ONE <<< RSH) : '0;
  localparam logic signed [Q-1:0] HI =
    OS ? (ONE <<< (DW - 1)) - ONE : (ONE <<< DW) - ONE;
  localparam logic signed [Q-1:0] LO =
    OS ? -(ONE <<< (DW - 1)) : '0;

  // Operands are widened so that the signed product and rounding are exact.
  logic signed [Q-1:0] a_x;
  logic signed [Q-1:0] b_x;
  logic signed [Q-1:0] prod;
  logic signed [Q-1:0] sum;
  logic signed [Q-1:0] r;
  logic [DW-1:0]       d_c;
  logic                o_c;

  logic                 en;
  logic [N-1:0]         vld;
  logic [N-1:0][DW-1:0] dat;
  logic [N-1:0]         ovs;
  logic [N:0]           vin;
  logic [N:0][DW-1:0]   dch;
  logic [N:0]           och;
  logic                 unused_id;

  assign unused_id = ID[0];

  assign a_x  = {{(Q-din0_WIDTH){S0 & din0[din0_WIDTH-1]}}, din0};
  assign b_x  = {{(Q-din1_WIDTH){S1 & din1[din1_WIDTH-1]}}, din1};
  assign prod = a_x * b_x;
  assign sum  = prod + RND;
  assign r    = sum >>> SHIFT;

  // Range check and clamp/wrap of the shifted product.
  always_comb begin
    d_c = r[DW-1:0];
    o_c = 1'b0;
    if (r > HI) begin
      o_c = 1'b1;
      if (SATURATE != 0) d_c = HI[DW-1:0];
    end else if (r < LO) begin
      o_c = 1'b1;
      if (SATURATE != 0) d_c = LO[DW-1:0];
    end
  end

  assign out_valid = vld[N-1];
  assign dout      = dat[N-1];
  assign ovf       = ovs[N-1];
  assign en        = ~out_valid | out_ready;
  assign in_ready  = en & ~flush;

  assign vin = {vld, in_valid};
  assign dch = {dat, d_c};
  assign och = {ovs, o_c};

  // Valid bits shift as one; flush clears them all.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld <= '0;
    end else if (flush) begin
      vld <= '0;
    end else if (en) begin
      vld <= vin[N-1:0];
    end
  end

  // Payload moves only with a valid beat, so dout holds across bubbles/flush.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dat <= '0;
      ovs <= '0;
    end else if (en && !flush) begin
      for (int i = 0; i < N; i++) begin
        if (vin[i]) begin
          dat[i] <= dch[i];
          ovs[i] <= och[i];
        end
      end
    end
  end

  // Count delivered overflow beats, sticking at all-ones.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ovf_cnt <= '0;
    end else if (flush) begin
      ovf_cnt <= '0;
    end else if (out_valid && out_ready && ovf && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_case_mul_pipe_sat.sv
// tb_case_mul_pipe_sat: directed checks of the default build (u0) and a
// ROUND=0 / SATURATE=0 build (u1) driven by the same stimulus.
module tb_case_mul_pipe_sat;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        flush;
  logic        in_valid;
  logic [13:0] din0;
  logic [11:0] din1;
  logic        out_ready;

  logic        in_ready, out_valid, ovf;
  logic [13:0] dout;
  logic [7:0]  ovf_cnt;
  logic        in_ready2, out_valid2, ovf2;
  logic [13:0] dout2;
  logic [7:0]  ovf_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 ap_clk = ~ap_clk;

  case_mul_pipe_sat u0 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .ovf(ovf), .ovf_cnt(ovf_cnt)
  );

  case_mul_pipe_sat #(.ID(2), .ROUND(0), .SATURATE(0)) u1 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2),
    .din0(din0), .din1(din1),
    .out_valid(out_valid2), .out_ready(out_ready),
    .dout(dout2), .ovf(ovf2), .ovf_cnt(ovf_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; checks exact 3-cycle latency and both results.
  task automatic beat(input string tag,
                      input logic [13:0] a, input logic [11:0] b,
                      input logic [13:0] ed, input logic eo,
                      input logic [13:0] ed2, input logic eo2);
    din0 = a;
    din1 = b;
    in_valid = 1'b1;
    @(posedge ap_clk);
    #1 in_valid = 1'b0;
    @(negedge ap_clk);
    chk({tag, " early1"}, 32'(out_valid), 32'd0);
    @(negedge ap_clk);
    chk({tag, " early2"}, 32'(out_valid), 32'd0);
    @(negedge ap_clk);
    chk({tag, " valid"}, 32'(out_valid), 32'd1);
    chk({tag, " dout"}, 32'(dout), 32'(ed));
    chk({tag, " ovf"}, 32'(ovf), 32'(eo));
    chk({tag, " valid2"}, 32'(out_valid2), 32'd1);
    chk({tag, " dout2"}, 32'(dout2), 32'(ed2));
    chk({tag, " ovf2"}, 32'(ovf2), 32'(eo2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int rcv;
    int seen;
    logic [13:0] e;

    ap_rst_n  = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    din0      = '0;
    din1      = '0;

    #2;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst dout", 32'(dout), 32'd0);
    chk("rst ovf", 32'(ovf), 32'd0);
    chk("rst ovf_cnt", 32'(ovf_cnt), 32'd0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    chk("rel in_ready", 32'(in_ready), 32'd1);

    @(negedge ap_clk);
    beat("t1", 14'd1000, 12'd1024, 14'd1000, 1'b0, 14'd1000, 1'b0);
    beat("max", 14'd8191, 12'd1024, 14'd8191, 1'b0, 14'd8191, 1'b0);
    beat("t2p", 14'd3, 12'd171, 14'd1, 1'b0, 14'd0, 1'b0);
    beat("t2n", 14'(-3), 12'd171, 14'(-1), 1'b0, 14'(-1), 1'b0);
    chk("t2 cnt", 32'(ovf_cnt), 32'd0);
    beat("t3a", 14'(-8192), 12'(-2048), 14'd8191, 1'b1, 14'd0, 1'b1);
    beat("t3b", 14'(-8192), 12'(-2047), 14'd8191, 1'b1, 14'(-8), 1'b1);
    beat("t3c", 14'(-8192), 12'd2047, 14'(-8192), 1'b1, 14'd8, 1'b1);
    @(negedge ap_clk);
    chk("t3 cnt", 32'(ovf_cnt), 32'd3);
    chk("t3 cnt2", 32'(ovf_cnt2), 32'd3);
    chk("t3 drained", 32'(out_valid), 32'd0);

    sent = 0;
    rcv  = 0;
    for (int cyc = 0; cyc < 40 && rcv < 10; cyc++) begin
      @(negedge ap_clk);
      out_ready = !(cyc >= 4 && cyc <= 8);
      in_valid  = (sent < 10);
      din0      = 14'(100 * (sent + 1));
      din1      = 12'd1024;
      #1;
      e = 14'(100 * (rcv + 1));
      if (cyc >= 4 && cyc <= 8) begin
        chk("t4 stall in_ready", 32'(in_ready), 32'd0);
        chk("t4 stall dout", 32'(dout), 32'(e));
      end
      if (out_valid && out_ready) begin
        chk("t4 dout", 32'(dout), 32'(e));
        chk("t4 dout2", 32'(dout2), 32'(e));
        rcv++;
      end
      if (in_valid && in_ready) sent++;
    end
    @(negedge ap_clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("t4 received", 32'(rcv), 32'd10);
    chk("t4 sent", 32'(sent), 32'd10);
    seen = 0;
    repeat (4) begin
      @(negedge ap_clk);
      if (out_valid) seen++;
    end
    chk("t4 no dup", 32'(seen), 32'd0);

    for (int k = 0; k < 3; k++) begin
      din0     = 14'(-8192);
      din1     = 12'(-2048);
      in_valid = 1'b1;
      @(negedge ap_clk);
    end
    chk("t5 inflight", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    ap_rst_n = 1'b0;
    #1;
    chk("t5 async valid", 32'(out_valid), 32'd0);
    chk("t5 async dout", 32'(dout), 32'd0);
    chk("t5 async cnt", 32'(ovf_cnt), 32'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    chk("t5 in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (6) begin
      @(negedge ap_clk);
      if (out_valid || out_valid2) seen++;
    end
    chk("t5 no ghost", 32'(seen), 32'd0);

    flush    = 1'b1;
    in_valid = 1'b1;
    din0     = 14'd1000;
    din1     = 12'd1024;
    #1;
    chk("t5 flush in_ready", 32'(in_ready), 32'd0);
    @(negedge ap_clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge ap_clk);
      if (out_valid) seen++;
    end
    chk("t5 flush drop", 32'(seen), 32'd0);

    din0     = 14'(-8192);
    din1     = 12'(-2048);
    in_valid = 1'b1;
    repeat (300) @(negedge ap_clk);
    in_valid = 1'b0;
    repeat (4) @(negedge ap_clk);
    chk("t6 cnt sat", 32'(ovf_cnt), 32'd255);
    chk("t6 cnt2 sat", 32'(ovf_cnt2), 32'd255);
    chk("t6 dout", 32'(dout), 32'h1fff);
    flush = 1'b1;
    @(negedge ap_clk);
    flush = 1'b0;
    chk("t6 flush cnt", 32'(ovf_cnt), 32'd0);
    chk("t6 flush cnt2", 32'(ovf_cnt2), 32'd0);
    chk("t6 flush dout", 32'(dout), 32'h1fff);
    chk("t6 flush valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
